// File: rtl/matmul_pkg.sv
// Shared types and constants for the 3x3 matrix-multiply sequencer.
package matmul_pkg;

    localparam int DIM        = 3;
    localparam int NUM_BYTES  = 2 * DIM * DIM;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 2 * DATA_W_DEF + 2;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

endpackage

// File: rtl/matmul_sequencer_if.sv
// Operand-stream / result-stream bundle of the matrix-multiply sequencer.
interface matmul_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2 * DATA_W + 2
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic [ACC_W-1:0]  result;
    logic              result_valid;
    logic              result_ready;
    logic              busy;
    logic              done;

    modport master (
        output data_in, data_valid, result_ready,
        input  data_ready, result, result_valid, busy, done
    );

    modport slave (
        input  data_in, data_valid, result_ready,
        output data_ready, result, result_valid, busy, done
    );
endinterface

// File: rtl/matmul_sequencer_mac_unit.sv
// Single-multiplier accumulator; acc_o is the running sum including the current product.
// MATMUL_SIGNED_EN selects two's-complement operands instead of unsigned.
module mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2 * DATA_W + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              acc_clear_i,
    input  logic              acc_en_i,
    output logic [ACC_W-1:0]  acc_o
);
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] product;

`ifdef MATMUL_SIGNED_EN
    logic signed [ACC_W-1:0] a_ext, b_ext;
    assign a_ext   = ACC_W'($signed(a_i));
    assign b_ext   = ACC_W'($signed(b_i));
    assign product = a_ext * b_ext;
`else
    assign product = ACC_W'(a_i) * ACC_W'(b_i);
`endif

    assign acc_o = acc_q + product;

    always_comb begin
        acc_d = acc_q;
        if (acc_clear_i) begin
            acc_d = '0;
        end else if (acc_en_i) begin
            acc_d = acc_o;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/matmul_sequencer.sv
// 3x3 C = A x B sequencer: loads 18 operand bytes, emits nine results row-major.
// Signedness of the arithmetic is chosen by MATMUL_SIGNED_EN inside mac_unit.
//   state      | meaning
//   ST_LOAD    | accepting operand bytes (A row-major, then B row-major)
//   ST_COMPUTE | one multiply-accumulate per cycle, k = 0..2
//   ST_EMIT    | holding result until the consumer accepts it
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = 2 * DATA_W + 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    matmul_sequencer_if.slave  bus
);
    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [1:0]        i_q, i_d, j_q, j_d, k_q, k_d;
    logic [ACC_W-1:0]  result_q, result_d;
    logic              done_q, done_d;
    logic              load_we, acc_clear, acc_en;
    logic [DATA_W-1:0] op_q [NUM_BYTES];
    logic [4:0]        a_idx, b_idx;
    logic [ACC_W-1:0]  mac_sum;

    assign a_idx = 5'(i_q) * 5'(DIM) + 5'(k_q);
    assign b_idx = 5'(DIM * DIM) + 5'(k_q) * 5'(DIM) + 5'(j_q);

    mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk         (clk),
        .reset       (reset),
        .a_i         (op_q[a_idx]),
        .b_i         (op_q[b_idx]),
        .acc_clear_i (acc_clear),
        .acc_en_i    (acc_en),
        .acc_o       (mac_sum)
    );

    assign bus.data_ready   = (state_q == ST_LOAD);
    assign bus.result_valid = (state_q == ST_EMIT);
    assign bus.busy         = (state_q != ST_LOAD);
    assign bus.result       = result_q;
    assign bus.done         = done_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        result_d  = result_q;
        done_d    = 1'b0;
        load_we   = 1'b0;
        acc_clear = 1'b0;
        acc_en    = 1'b0;

        // clear wins over any handshake offered in the same cycle
        if (clear) begin
            state_d   = ST_LOAD;
            cnt_d     = '0;
            i_d       = '0;
            j_d       = '0;
            k_d       = '0;
            acc_clear = 1'b1;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    if (bus.data_valid) begin
                        load_we = 1'b1;
                        if (cnt_q == 5'(NUM_BYTES - 1)) begin
                            cnt_d     = '0;
                            i_d       = '0;
                            j_d       = '0;
                            k_d       = '0;
                            acc_clear = 1'b1;
                            state_d   = ST_COMPUTE;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    acc_en = 1'b1;
                    if (k_q == 2'(DIM - 1)) begin
                        result_d = mac_sum;
                        state_d  = ST_EMIT;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
                ST_EMIT: begin
                    if (bus.result_ready) begin
                        acc_clear = 1'b1;
                        k_d       = '0;
                        if (i_q == 2'(DIM - 1) && j_q == 2'(DIM - 1)) begin
                            i_d     = '0;
                            j_d     = '0;
                            done_d  = 1'b1;
                            state_d = ST_LOAD;
                        end else begin
                            if (j_q == 2'(DIM - 1)) begin
                                j_d = '0;
                                i_d = i_q + 2'd1;
                            end else begin
                                j_d = j_q + 2'd1;
                            end
                            state_d = ST_COMPUTE;
                        end
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_LOAD;
            cnt_q    <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Operand storage carries no reset; contents are always fully rewritten before use.
    always_ff @(posedge clk) begin
        if (load_we) begin
            op_q[cnt_q] <= bus.data_in;
        end
    end
endmodule
